// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the controller state encoding, the op codes and the iteration count.
// It also holds the start-to-done latencies that the CPU Control FSM and the
// bench rely on.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MULDIV_ITER = 32;

    // Cycles from the accepting cycle (cycle 0) to the done pulse.
    localparam int MULT_DONE_LAT  = 33;
    localparam int DIV_DONE_LAT   = 34;
    localparam int DIVZ_DONE_LAT  = 1;

endpackage

// File: rtl/div_restore_step.sv
// One combinational step of restoring division on unsigned magnitudes.
// Ports:
//   rem_i     partial remainder before the step (always < divisor)
//   bit_i     next dividend bit shifted into the remainder
//   divisor_i divisor magnitude
//   rem_o     partial remainder after the step
//   qbit_o    quotient bit produced by this step
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    // The shifted remainder needs one extra bit: a divisor magnitude of
    // 2^(WIDTH-1) allows a shifted remainder up to 2^WIDTH - 1.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // A clear borrow bit means the trial subtraction fits. The result is then
    // below the divisor, so it fits in WIDTH bits.
    assign qbit_o = ~diff[WIDTH];
    assign rem_o  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide unit placed ahead of the Hi/Lo registers.
// MULT uses radix-2 Booth, one step per cycle.
// DIV uses restoring division on magnitudes, followed by a sign fix-up cycle.
// Ports:
//   clk          system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      operation request, accepted only when not busy
//   op_i         0 = MULT, 1 = DIV (sampled with start_i)
//   a_i, b_i     signed operands, latched on accept
//   busy_o       high while iterating
//   done_o       one-cycle completion pulse
//   div_zero_o   pulses with done_o when a DIV had a zero divisor
//   hi_o, lo_o   MULT: product high/low; DIV: remainder/quotient
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_e    state_q, state_d;
    // Working accumulator. MULT: {acc_hi, acc_lo, qm1} is the Booth register.
    // DIV: acc_hi holds the remainder and acc_lo holds the dividend, which is
    // shifted out as quotient bits are shifted in.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             qm1_q, qm1_d;
    // Multiplicand for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    // Booth add/subtract is done one bit wider so that subtracting a
    // most-negative multiplicand cannot overflow before the shift.
    logic [WIDTH:0]   booth_hi_ext;
    logic [WIDTH:0]   booth_m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] booth_hi_nxt;
    logic [WIDTH-1:0] booth_lo_nxt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    assign booth_hi_ext = {acc_hi_q[WIDTH-1], acc_hi_q};
    assign booth_m_ext  = {opnd_q[WIDTH-1], opnd_q};

    always_comb begin
        booth_sum = booth_hi_ext;
        case ({acc_lo_q[0], qm1_q})
            2'b01:   booth_sum = booth_hi_ext + booth_m_ext;
            2'b10:   booth_sum = booth_hi_ext - booth_m_ext;
            default: booth_sum = booth_hi_ext;
        endcase
    end

    // Arithmetic shift right of {sum, lo, qm1}. The Booth partial result
    // always fits back into WIDTH bits after the shift.
    assign booth_hi_nxt = booth_sum[WIDTH:1];
    assign booth_lo_nxt = {booth_sum[0], acc_lo_q[WIDTH-1:1]};

    // Negating the most-negative value yields the same bit pattern. Read as
    // unsigned, that is the correct magnitude.
    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_hi_q),
        .bit_i     (acc_lo_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        qm1_d     = qm1_q;
        opnd_d    = opnd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    qm1_d    = 1'b0;
                    if (op_i == OP_MULT) begin
                        state_d  = ST_MULT;
                        opnd_d   = a_i;
                        acc_lo_d = b_i;
                        busy_d   = 1'b1;
                    end else if (b_i == '0) begin
                        // Report straight away; hi/lo keep the last result.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d   = ST_DIV;
                        opnd_d    = b_mag;
                        acc_lo_d  = a_mag;
                        neg_quo_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
                        neg_rem_d = a_i[WIDTH-1];
                        busy_d    = 1'b1;
                    end
                end
            end

            ST_MULT: begin
                acc_hi_d = booth_hi_nxt;
                acc_lo_d = booth_lo_nxt;
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hi_d    = booth_hi_nxt;
                    lo_d    = booth_lo_nxt;
                end else begin
                    busy_d = 1'b1;
                end
            end

            ST_DIV: begin
                acc_hi_d = step_rem;
                acc_lo_d = {acc_lo_q[WIDTH-2:0], step_qbit};
                cnt_d    = cnt_q + CNT_W'(1);
                busy_d   = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                // Truncating division: the quotient sign is the XOR of the
                // operand signs, and the remainder follows the dividend.
                state_d = ST_DONE;
                done_d  = 1'b1;
                lo_d    = neg_quo_q ? -acc_lo_q : acc_lo_q;
                hi_d    = neg_rem_q ? -acc_hi_q : acc_hi_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            qm1_q     <= 1'b0;
            opnd_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            qm1_q     <= qm1_d;
            opnd_q    <= opnd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: the results, the latencies, the busy window,
// divide-by-zero, start while busy, reset mid-operation and back-to-back issue.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_i    (reset),
        .start_i    (start),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (div_zero),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation and track it to done.
    // b2b=1: the caller is at the sampling point of a DONE cycle, so start is
    //        raised in that cycle.
    // intr>0: a stray start with other operands is pulsed in that busy cycle.
    task automatic run_op(input string tag, input logic op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz, input bit b2b,
                          input int intr);
        int  lat;
        bit  busy_ok;
        if (!b2b) @(negedge clk);
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            if (k == intr) begin
                start = 1'b1;
                op    = OP_DIV;
                a     = 32'd100;
                b     = 32'd0;
            end else begin
                start = 1'b0;
            end
            if (done) lat = k;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".busy_window"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, ".hi"}, hi, exp_hi);
        chk({tag, ".lo"}, lo, exp_lo);
        chk({tag, ".div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
        $display("op=%s a=%h b=%h lat=%0d hi=%h lo=%h dz=%b", tag, a_v, b_v, lat, hi, lo, div_zero);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.done", {31'b0, done}, 32'd0);
        chk("reset.dz", {31'b0, div_zero}, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        reset = 1'b0;

        run_op("mul_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, MULT_DONE_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 0);
        run_op("mul_max", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, MULT_DONE_LAT,
               32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("mul_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, MULT_DONE_LAT,
               32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_DONE_LAT,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_DONE_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 0);
        run_op("div_zero", OP_DIV, 32'd5, 32'd0, DIVZ_DONE_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("div_zero.pulse_done", {31'b0, done}, 32'd0);
        chk("div_zero.pulse_dz", {31'b0, div_zero}, 32'd0);

        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_DONE_LAT,
               32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
        run_op("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, DIV_DONE_LAT,
               32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 1'b0, 0);

        // A stray start in busy cycle 5 must not disturb the operation.
        run_op("mul_ignore", OP_MULT, 32'd7, 32'hFFFF_FFFD, MULT_DONE_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 5);
        // Back-to-back: each start is raised in the previous DONE cycle.
        run_op("b2b_mul", OP_MULT, 32'h0001_2345, 32'h0000_0010, MULT_DONE_LAT,
               32'h0000_0000, 32'h0012_3450, 1'b0, 1'b1, 0);
        run_op("b2b_div", OP_DIV, 32'd100, 32'd7, DIV_DONE_LAT,
               32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1, 0);

        // Reset in cycle 10 of a MULT.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst.busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst.busy", {31'b0, busy}, 32'd0);
        chk("midrst.done", {31'b0, done}, 32'd0);
        chk("midrst.dz", {31'b0, div_zero}, 32'd0);
        chk("midrst.hi", hi, 32'd0);
        chk("midrst.lo", lo, 32'd0);
        $display("op=midrst busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("midrst.idle", 32'(dones), 32'd0);

        run_op("mul_after_rst", OP_MULT, 32'hFFFF_FFFF, 32'd2, MULT_DONE_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequential signed multiply/divide unit for the multicycle CPU datapath. It sits between the A/B operand registers (or the memory-operand registers) and the Hi/Lo registers. It replaces the free-running Mult/Div pair and their `resetlocal` pulse with an explicit start/done handshake. The Control FSM drives `start`/`op`, waits for `done`, then pulses `Hi_load`/`Lo_load`; `div_zero` feeds the ZeroDivision exception path.

## Interface
- `WIDTH`, default 32: operand width; `hi`/`lo` are each `WIDTH` bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted only when `busy`==0.
- `op`  in  1  0 = MULT, 1 = DIV; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend (signed); latched on accept.
- `b`  in  WIDTH  multiplier / divisor (signed); latched on accept.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  one-cycle pulse coincident with `done` when DIV has `b`==0.
- `hi`  out  WIDTH  MULT: product[63:32]; DIV: remainder.
- `lo`  out  WIDTH  MULT: product[31:0]; DIV: quotient.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE/DONE + `start`:
  - `op`=0 → MULT, iteration counter = 0.
  - `op`=1, `b`≠0 → DIV.
  - `op`=1, `b`==0 → DONE directly with `div_zero` set.
- MULT: radix-2 Booth, one step per cycle over a 2·WIDTH+1-bit accumulator {hi, lo, q-1}.
  - Each step: add/sub multiplicand per (lo[0], q-1), then arithmetic shift right by 1.
  - After WIDTH steps → DONE. `{hi,lo}` = full signed 64-bit product.
- DIV: restoring division on magnitudes |a|, |b|, one quotient bit per cycle.
  - After WIDTH steps → FIX.
  - FIX: negate quotient if sign(a)≠sign(b); remainder takes sign of `a` (MIPS semantics); → DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or the next operation's first state if `start` is high.
- `hi`/`lo` update only on entry to DONE and hold until the next completion.
- Divide-by-zero leaves `hi`/`lo` unchanged.
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0, no flag.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- `a`/`b` may change after accept without effect.
- Reset (at any time, including mid-operation): state IDLE; `busy`, `done`, `div_zero` = 0; `hi`, `lo`, accumulators and counter = 0.

## Timing
- Cycle 0 is the cycle in which `start` is high and accepted.
- MULT: `busy` high cycles 1..32; `done` and `hi`/`lo` valid in cycle 33.
- DIV: `busy` high cycles 1..33 (32 iterations + FIX); `done` in cycle 34.
- DIV by zero: `done`=`div_zero`=1 in cycle 1; `busy` never asserted.
- `busy`=0 in IDLE and DONE. Back-to-back issue: `start` in the DONE cycle is accepted, and that DONE cycle becomes cycle 0 of the new operation.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `muldiv_pkg` holds:
  - state enum (IDLE, MULT, DIV, FIX, DONE);
  - `OP_MULT`=1'b0, `OP_DIV`=1'b1;
  - `MULDIV_ITER`=32;
  - the `done`-latency constants 33, 34 and 1, shared with Control and the bench.
- One natural sub-module: `div_restore_step`, a combinational single-bit restoring step (partial remainder in, divisor in, next remainder + quotient bit out). The Booth step stays inline.

## Test plan
1. MULT: `a`=7, `b`=-3 (0xFFFFFFFD) → cycle 33: `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high cycles 1..32.
2. MULT: `a`=`b`=0x7FFFFFFF → `hi`=0x3FFFFFFF, `lo`=0x00000001; then 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
3. DIV: `a`=-7, `b`=2 → cycle 34: `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1); also 7/-2 → `lo`=0xFFFFFFFD, `hi`=1.
4. DIV by zero after test 3: `a`=5, `b`=0 → cycle 1: `done`=`div_zero`=1, `hi`/`lo` still 0xFFFFFFFF/0xFFFFFFFD.
5. DIV: 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
6. Control cases:
   - `start` pulsed with new operands in cycle 5 of a MULT → ignored; result matches the original operands.
   - `reset` in cycle 10 of a MULT → next cycle all outputs 0, state IDLE.
   - A fresh `start` completes normally at +33.
   - Back-to-back `start` in a DONE cycle completes 33/34 cycles later.
